// File: rtl/fm_sb_playback.sv
// Spy-buffer playback: reads a preloaded BRAM and replays its words
// as an fm_rt stream (fm_data/fm_vld), single-shot or looping.
module fm_sb_playback #(
    parameter int DW         = 96,
    parameter int MON_DW_MAX = 256,
    parameter int AW         = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pb_mode,
    input  logic                  pb_start,
    input  logic [AW:0]           pb_len,
    input  logic [7:0]            pb_gap,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [DW-1:0]         mem_rd_data,
    output logic [MON_DW_MAX-1:0] fm_data,
    output logic                  fm_vld,
    output logic                  pb_busy,
    output logic                  pb_done,
    output logic [15:0]           pb_loop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [AW:0]             r_len;
    logic [7:0]              r_gap;
    logic [7:0]              r_gcnt;
    logic [AW-1:0]           r_addr;
    logic [AW-1:0]           r_rd_addr;
    logic                    r_rd_en;
    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_loop_cnt;
    logic [RD_LATENCY-1:0]   r_vpipe;
    logic                    r_fm_vld;
    logic [MON_DW_MAX-1:0]   r_fm_data;

    logic                    w_abort;
    logic                    w_start_ok;
    logic                    w_last;
    logic                    w_wrap;
    logic [AW-1:0]           w_nxt;

    assign w_abort    = (pb_mode == 2'd0) || (pb_mode == 2'd3);
    assign w_start_ok = pb_start && (pb_mode == 2'd1 || pb_mode == 2'd2)
                        && (pb_len != '0);
    assign w_last     = ({1'b0, r_rd_addr} == r_len - 1'b1);
    assign w_wrap     = w_last && (r_mode == 2'd2) && (pb_mode == 2'd2);
    assign w_nxt      = w_last ? '0 : r_rd_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_len      <= '0;
            r_gap      <= '0;
            r_gcnt     <= '0;
            r_addr     <= '0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_loop_cnt <= '0;
            r_vpipe    <= '0;
            r_fm_vld   <= 1'b0;
            r_fm_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_vpipe[0] <= r_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_fm_vld <= r_vpipe[RD_LATENCY-1];
            if (r_vpipe[RD_LATENCY-1]) begin
                r_fm_data <= MON_DW_MAX'(mem_rd_data);
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_mode     <= pb_mode;
                        r_len      <= pb_len;
                        r_gap      <= pb_gap;
                        r_rd_addr  <= '0;
                        r_loop_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w_abort || (w_last && !w_wrap)) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        if (w_wrap) begin
                            r_loop_cnt <= r_loop_cnt + 16'd1;
                        end
                        if (r_gap != 8'd0) begin
                            r_addr  <= w_nxt;
                            r_gcnt  <= r_gap;
                            r_rd_en <= 1'b0;
                            r_state <= S_GAP;
                        end else begin
                            r_rd_addr <= w_nxt;
                        end
                    end
                end
                S_GAP: begin
                    if (w_abort) begin
                        r_state <= S_DRAIN;
                    end else if (r_gcnt == 8'd1) begin
                        r_rd_addr <= r_addr;
                        r_rd_en   <= 1'b1;
                        r_state   <= S_PLAY;
                    end else begin
                        r_gcnt <= r_gcnt - 8'd1;
                    end
                end
                S_DRAIN: begin
                    // done lands the cycle after the last in-flight word is shown
                    if (r_vpipe == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign fm_data     = r_fm_data;
    assign fm_vld      = r_fm_vld;
    assign pb_busy     = r_busy;
    assign pb_done     = r_done;
    assign pb_loop_cnt = r_loop_cnt;

endmodule
